// File: rtl/flex_rx_timer.sv
// Run-time configurable bit timer for the serial receiver: emits a mid-bit
// sample strobe per bit and a one-cycle done pulse after the last bit.
module flex_rx_timer #(
   parameter int PERIOD_BITS  = 14,
   parameter int BIT_CNT_BITS = 5
) (
   input  logic                    clk,
   input  logic                    n_rst,
   input  logic                    enable_timer,
   input  logic [PERIOD_BITS-1:0]  bit_period,
   input  logic [BIT_CNT_BITS-1:0] packet_size,
   output logic                    shift_enable,
   output logic                    packet_done,
   output logic [BIT_CNT_BITS-1:0] bit_count,
   output logic                    timer_busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                  state_q;
   logic [PERIOD_BITS-1:0]  clkCount_q;
   logic [BIT_CNT_BITS-1:0] bitCount_q;
   logic [PERIOD_BITS-1:0]  period_q;
   logic [PERIOD_BITS-1:0]  half_q;
   logic [BIT_CNT_BITS-1:0] size_q;

   logic [PERIOD_BITS-1:0]  period_d;
   logic [PERIOD_BITS-1:0]  half_d;
   logic [BIT_CNT_BITS-1:0] size_d;
   logic [BIT_CNT_BITS-1:0] bitCountInc;

   // Clamp the incoming config so a period below 2 still leaves room for a
   // mid-bit strobe and an empty packet still issues one strobe.
   always_comb begin
      period_d    = (bit_period < PERIOD_BITS'(2)) ? PERIOD_BITS'(2) : bit_period;
      half_d      = period_d >> 1;
      size_d      = (packet_size == '0) ? BIT_CNT_BITS'(1) : packet_size;
      bitCountInc = bitCount_q + BIT_CNT_BITS'(1);
   end

   assign shift_enable = (state_q == RUN) && (clkCount_q == half_q);
   assign packet_done  = (state_q == DONE);
   assign timer_busy   = (state_q != IDLE);
   assign bit_count    = bitCount_q;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q    <= IDLE;
         clkCount_q <= '0;
         bitCount_q <= '0;
         period_q   <= PERIOD_BITS'(2);
         half_q     <= PERIOD_BITS'(1);
         size_q     <= BIT_CNT_BITS'(1);
      end else begin
         case (state_q)
            IDLE: begin
               clkCount_q <= '0;
               bitCount_q <= '0;
               if (enable_timer) begin
                  period_q <= period_d;
                  half_q   <= half_d;
                  size_q   <= size_d;
                  state_q  <= RUN;
               end
            end
            RUN: begin
               if (!enable_timer) begin
                  state_q    <= IDLE;
                  clkCount_q <= '0;
                  bitCount_q <= '0;
               end else begin
                  if (clkCount_q == period_q - PERIOD_BITS'(1)) begin
                     clkCount_q <= '0;
                  end else begin
                     clkCount_q <= clkCount_q + PERIOD_BITS'(1);
                  end
                  // The last strobe of the packet moves straight into the done cycle.
                  if (shift_enable) begin
                     bitCount_q <= bitCountInc;
                     if (bitCountInc == size_q) begin
                        state_q    <= DONE;
                        clkCount_q <= '0;
                     end
                  end
               end
            end
            DONE: begin
               clkCount_q <= '0;
               bitCount_q <= '0;
               if (enable_timer) begin
                  period_q <= period_d;
                  half_q   <= half_d;
                  size_q   <= size_d;
                  state_q  <= RUN;
               end else begin
                  state_q <= IDLE;
               end
            end
            default: begin
               state_q    <= IDLE;
               clkCount_q <= '0;
               bitCount_q <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_flex_rx_timer.sv
// Directed bench for flex_rx_timer: a table of single-cycle snapshots plus
// cycle-by-cycle sequences for full packets, config changes, abort and reset.
module tb_flex_rx_timer;

   logic        clk;
   logic        n_rst;
   logic        enable_timer;
   logic [13:0] bit_period;
   logic [4:0]  packet_size;
   logic        shift_enable;
   logic        packet_done;
   logic [4:0]  bit_count;
   logic        timer_busy;

   int checks = 0;
   int errors = 0;
   int cycle  = 0;

   flex_rx_timer #(
      .PERIOD_BITS (14),
      .BIT_CNT_BITS(5)
   ) dut (
      .clk         (clk),
      .n_rst       (n_rst),
      .enable_timer(enable_timer),
      .bit_period  (bit_period),
      .packet_size (packet_size),
      .shift_enable(shift_enable),
      .packet_done (packet_done),
      .bit_count   (bit_count),
      .timer_busy  (timer_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int period;
      int size;
      int atCycle;
      int expShift;
      int expDone;
      int expCount;
      int expBusy;
   } vec_t;

   vec_t vecs[15];

   task automatic checkVal(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // Inputs change just after a negedge, so they are sampled at the end of the current cycle.
   task automatic nextCycle();
      @(negedge clk);
      cycle++;
   endtask

   task automatic doReset();
      n_rst        = 1'b0;
      enable_timer = 1'b0;
      bit_period   = 14'd10;
      packet_size  = 5'd9;
      @(negedge clk);
      @(negedge clk);
      n_rst = 1'b1;
      cycle = 0;
   endtask

   task automatic startPacket(input int period, input int size);
      bit_period   = 14'(period);
      packet_size  = 5'(size);
      enable_timer = 1'b1;
      cycle        = 0;
   endtask

   task automatic stepTo(input int target);
      while (cycle < target) nextCycle();
   endtask

   task automatic applyStimulus(input vec_t v);
      doReset();
      startPacket(v.period, v.size);
      stepTo(v.atCycle);
   endtask

   task automatic checkOutput(input int idx, input vec_t v);
      checkVal($sformatf("vec%0d shift_enable", idx), int'(shift_enable), v.expShift);
      checkVal($sformatf("vec%0d packet_done", idx), int'(packet_done), v.expDone);
      checkVal($sformatf("vec%0d bit_count", idx), int'(bit_count), v.expCount);
      checkVal($sformatf("vec%0d timer_busy", idx), int'(timer_busy), v.expBusy);
   endtask

   // Strobe/done positions from the cycle formulas; runStart is the first RUN cycle.
   function automatic int strobeAt(input int c, input int runStart, input int per, input int size);
      int first;
      first = runStart + per / 2;
      if (c < first) return 0;
      if ((c - first) % per != 0) return 0;
      return ((c - first) / per < size) ? 1 : 0;
   endfunction

   function automatic int doneAt(input int c, input int runStart, input int per, input int size);
      return (c == runStart + per / 2 + (size - 1) * per + 1) ? 1 : 0;
   endfunction

   initial begin
      n_rst        = 1'b0;
      enable_timer = 1'b0;
      bit_period   = 14'd10;
      packet_size  = 5'd9;

      vecs[0]  = '{10, 9,  1, 0, 0, 0, 1};
      vecs[1]  = '{10, 9,  6, 1, 0, 0, 1};
      vecs[2]  = '{10, 9,  7, 0, 0, 1, 1};
      vecs[3]  = '{10, 9, 86, 1, 0, 8, 1};
      vecs[4]  = '{10, 9, 87, 0, 1, 9, 1};
      vecs[5]  = '{ 4, 3,  3, 1, 0, 0, 1};
      vecs[6]  = '{ 4, 3, 11, 1, 0, 2, 1};
      vecs[7]  = '{ 4, 3, 12, 0, 1, 3, 1};
      vecs[8]  = '{ 0, 9,  2, 1, 0, 0, 1};
      vecs[9]  = '{ 0, 9,  4, 1, 0, 1, 1};
      vecs[10] = '{ 1, 9,  3, 0, 0, 1, 1};
      vecs[11] = '{ 5, 0,  3, 1, 0, 0, 1};
      vecs[12] = '{ 5, 0,  4, 0, 1, 1, 1};
      vecs[13] = '{ 3, 2,  6, 0, 1, 2, 1};
      vecs[14] = '{10, 9, 88, 0, 0, 0, 1};

      // Reset state while n_rst is held low.
      #12;
      checkVal("reset shift_enable", int'(shift_enable), 0);
      checkVal("reset packet_done", int'(packet_done), 0);
      checkVal("reset bit_count", int'(bit_count), 0);
      checkVal("reset timer_busy", int'(timer_busy), 0);

      for (int i = 0; i < 15; i++) begin
         applyStimulus(vecs[i]);
         checkOutput(i, vecs[i]);
      end

      // Full packet period 10 / size 9, then drop enable in the done cycle.
      doReset();
      startPacket(10, 9);
      for (int c = 1; c <= 87; c++) begin
         nextCycle();
         checkVal($sformatf("full shift@%0d", c), int'(shift_enable), strobeAt(c, 1, 10, 9));
         checkVal($sformatf("full done@%0d", c), int'(packet_done), doneAt(c, 1, 10, 9));
      end
      checkVal("full bit_count@87", int'(bit_count), 9);
      enable_timer = 1'b0;
      nextCycle();
      checkVal("full idle busy@88", int'(timer_busy), 0);
      checkVal("full idle count@88", int'(bit_count), 0);
      checkVal("full idle done@88", int'(packet_done), 0);

      // Config change mid-packet only affects the next packet.
      doReset();
      startPacket(10, 9);
      for (int c = 1; c <= 105; c++) begin
         if (cycle == 20) bit_period = 14'd6;
         nextCycle();
         if (c <= 87) begin
            checkVal($sformatf("cfg shift@%0d", c), int'(shift_enable), strobeAt(c, 1, 10, 9));
            checkVal($sformatf("cfg done@%0d", c), int'(packet_done), doneAt(c, 1, 10, 9));
         end else begin
            checkVal($sformatf("cfg shift@%0d", c), int'(shift_enable), strobeAt(c, 88, 6, 9));
         end
      end

      // Abort at cycle 30: no more strobes, no done pulse.
      doReset();
      startPacket(10, 9);
      stepTo(30);
      enable_timer = 1'b0;
      for (int c = 31; c <= 45; c++) begin
         nextCycle();
         checkVal($sformatf("abort busy@%0d", c), int'(timer_busy), 0);
         checkVal($sformatf("abort count@%0d", c), int'(bit_count), 0);
         checkVal($sformatf("abort done@%0d", c), int'(packet_done), 0);
         checkVal($sformatf("abort shift@%0d", c), int'(shift_enable), 0);
      end

      // Abort in a strobe cycle: strobe still visible, count clears at the edge.
      doReset();
      startPacket(10, 9);
      stepTo(16);
      checkVal("abort-on-strobe shift@16", int'(shift_enable), 1);
      enable_timer = 1'b0;
      nextCycle();
      checkVal("abort-on-strobe count@17", int'(bit_count), 0);
      checkVal("abort-on-strobe busy@17", int'(timer_busy), 0);

      // Back-to-back packets with enable held through both.
      doReset();
      startPacket(10, 9);
      for (int c = 1; c <= 174; c++) begin
         nextCycle();
         if (c <= 87) begin
            checkVal($sformatf("b2b shift@%0d", c), int'(shift_enable), strobeAt(c, 1, 10, 9));
         end else begin
            checkVal($sformatf("b2b shift@%0d", c), int'(shift_enable), strobeAt(c, 88, 10, 9));
         end
         checkVal($sformatf("b2b done@%0d", c), int'(packet_done),
                  (c == 87 || c == 174) ? 1 : 0);
      end
      checkVal("b2b bit_count@174", int'(bit_count), 9);

      // Asynchronous reset in cycle 100 of a back-to-back run.
      doReset();
      startPacket(10, 9);
      stepTo(100);
      checkVal("midreset busy before", int'(timer_busy), 1);
      checkVal("midreset count before", int'(bit_count), 1);
      #2;
      n_rst = 1'b0;
      #1;
      checkVal("midreset shift_enable", int'(shift_enable), 0);
      checkVal("midreset packet_done", int'(packet_done), 0);
      checkVal("midreset bit_count", int'(bit_count), 0);
      checkVal("midreset timer_busy", int'(timer_busy), 0);
      @(negedge clk);
      n_rst = 1'b1;
      enable_timer = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
